// File: rtl/xbar_pkg.sv
// Shared helpers for the registered byte-lane crossbar: select-code width,
// the "off" code value and the identity routing used at reset.
package xbar_pkg;

  // Upper bounds used to size the identity-config helper's return vector.
  localparam int MAX_N    = 8;
  localparam int MAX_SELW = 4;

  // Select code width: codes 0..n-1 pick an input, code n is "off".
  function automatic int sel_w(input int n);
    return $clog2(n + 1);
  endfunction

  // The select code that drives an output lane to zero.
  function automatic int off_code(input int n);
    return n;
  endfunction

  // Identity routing packed at a stride of selw bits: output j takes input j.
  function automatic logic [MAX_N*MAX_SELW-1:0] identity_cfg(input int n, input int selw);
    logic [MAX_N*MAX_SELW-1:0] cfg;
    cfg = '0;
    for (int j = 0; j < MAX_N; j++) begin
      if (j < n) begin
        for (int b = 0; b < MAX_SELW; b++) begin
          if (b < selw) cfg[j*selw + b] = j[b];
        end
      end
    end
    return cfg;
  endfunction

endpackage

// File: rtl/xbar_reg_n_if.sv
// Bus bundle for xbar_reg_n: data stage handshake plus configuration port.
//
// Handshake: a beat moves across an interface when valid && ready are both
// high at a rising clock edge; valid, once raised, stays high with stable
// data until that edge, and ready may depend combinationally on the far side.
interface xbar_reg_n_if
  import xbar_pkg::*;
#(
  parameter int N     = 3,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  localparam int SELW = sel_w(N);

  logic [N*WIDTH-1:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [N*SELW-1:0]  cfg_sel;
  logic               cfg_wr;
  logic               cfg_ok;
  logic               cfg_err;
  logic               err_clr;
  logic [N*SELW-1:0]  active_sel;
  logic [CNT_W-1:0]   beat_cnt;

  // Environment side: drives beats and configuration requests.
  modport master (
    output in_data, in_valid, out_ready, cfg_sel, cfg_wr, err_clr,
    input  in_ready, out_data, out_valid, cfg_ok, cfg_err, active_sel, beat_cnt
  );

  // Crossbar side.
  modport slave (
    input  in_data, in_valid, out_ready, cfg_sel, cfg_wr, err_clr,
    output in_ready, out_data, out_valid, cfg_ok, cfg_err, active_sel, beat_cnt
  );
endinterface

// File: rtl/xbar_lane_mux.sv
// One output lane of the crossbar: N:1 byte mux; the off code (or any code
// that does not name an input) yields zero.
module xbar_lane_mux #(
  parameter int N     = 3,
  parameter int WIDTH = 8,
  parameter int SELW  = 2
) (
  input  logic [N*WIDTH-1:0] data_i,
  input  logic [SELW-1:0]    sel_i,
  output logic [WIDTH-1:0]   data_o
);

  // Pick the selected input channel, zero otherwise.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_i == SELW'(i)) data_o = data_i[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/xbar_reg_n.sv
// Registered N-in/N-out byte-lane crossbar with validated routing register
// and a saturating beat counter that restarts on every successful commit.
// Optional macro XBAR_ALLOW_OFF_EN: when defined, the off code is a legal
// select and may appear on several outputs; otherwise a full permutation of
// inputs is required.
module xbar_reg_n
  import xbar_pkg::*;
#(
  parameter int N     = 3,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  xbar_reg_n_if.slave   bus
);

  localparam int                         SELW    = sel_w(N);
  localparam logic [SELW-1:0]            OFF     = SELW'(off_code(N));
  localparam logic [MAX_N*MAX_SELW-1:0]  ID_FULL = identity_cfg(N, SELW);
  localparam logic [N*SELW-1:0]          ID_CFG  = ID_FULL[N*SELW-1:0];

  logic [N*WIDTH-1:0] out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [N*SELW-1:0]  active_sel_q, active_sel_d;
  logic               cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic [N*WIDTH-1:0] routed;
  logic               cfg_ok;
  logic               in_ready;
  logic               accept;
  logic               commit;
  logic               handoff;

  // Routing datapath: one lane mux per output, steered by the committed config.
  for (genvar j = 0; j < N; j++) begin : g_lane
    xbar_lane_mux #(
      .N     (N),
      .WIDTH (WIDTH),
      .SELW  (SELW)
    ) u_lane (
      .data_i (bus.in_data),
      .sel_i  (active_sel_q[j*SELW +: SELW]),
      .data_o (routed[j*WIDTH +: WIDTH])
    );
  end

  // Legality of the requested config: codes in range, non-off codes distinct.
  always_comb begin
    cfg_ok = 1'b1;
    for (int j = 0; j < N; j++) begin
      if (int'(bus.cfg_sel[j*SELW +: SELW]) > N) cfg_ok = 1'b0;
`ifndef XBAR_ALLOW_OFF_EN
      if (bus.cfg_sel[j*SELW +: SELW] == OFF) cfg_ok = 1'b0;
`endif
      for (int k = 0; k < j; k++) begin
        if ((bus.cfg_sel[j*SELW +: SELW] == bus.cfg_sel[k*SELW +: SELW]) &&
            (bus.cfg_sel[j*SELW +: SELW] != OFF)) cfg_ok = 1'b0;
      end
    end
  end

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign handoff  = out_valid_q && bus.out_ready;
  assign commit   = bus.cfg_wr && cfg_ok;

  // Pipeline stage next state: load on accept, drain on hand-off, else hold.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_data_d  = routed;
      out_valid_d = 1'b1;
    end else if (handoff) begin
      out_valid_d = 1'b0;
    end
  end

  // Config register and sticky error next state; a bad write beats a clear.
  always_comb begin
    active_sel_d = active_sel_q;
    cfg_err_d    = cfg_err_q;
    if (commit) active_sel_d = bus.cfg_sel;
    if (bus.cfg_wr && !cfg_ok) cfg_err_d = 1'b1;
    else if (bus.err_clr)      cfg_err_d = 1'b0;
  end

  // Beat counter next state: commit clears, otherwise saturating count.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (commit) beat_cnt_d = '0;
    else if (handoff && (beat_cnt_q != {CNT_W{1'b1}})) beat_cnt_d = beat_cnt_q + 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      active_sel_q <= ID_CFG;
      cfg_err_q    <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      active_sel_q <= active_sel_d;
      cfg_err_q    <= cfg_err_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.cfg_ok     = cfg_ok;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.active_sel = active_sel_q;
  assign bus.beat_cnt   = beat_cnt_q;

endmodule
